aes_sbox_arbiter: RTL and testbench
===================================

AES_SBOX_ARBITER -- requirements
Module: aes_sbox_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; the reset port SHALL be named reset and the clock port clk.
REQ-002 The block SHALL have no parameters; all widths are fixed.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 key_req  input  1  key-expansion requester wants one SubWord; held high until key_ack.
REQ-006 key_word  input  32  key-expansion word to substitute; stable while key_req is high.
REQ-007 key_ack  output  1  one-cycle pulse; key_result valid in the same cycle.
REQ-008 key_result  output  32  registered SubWord of key_word; holds until the next key service.
REQ-009 enc_req, enc_word, enc_ack, enc_result  in/in/out/out  1/32/1/32  cipher-datapath requester, same rules as key_*.
REQ-010 sboxw  output  32  word driven to the single shared 4-byte S-box.
REQ-011 new_sboxw  input  32  combinational S-box result for sboxw, valid in the same cycle.
REQ-012 busy  output  1  high while the state is not IDLE.

Function
REQ-013 The FSM SHALL have states IDLE, SERVE_KEY and SERVE_ENC.
REQ-014 In IDLE with at least one eligible request, the FSM SHALL latch the winner's word into word_reg and move to SERVE_KEY or SERVE_ENC at the next edge.
REQ-015 In SERVE_x, sboxw SHALL equal word_reg; in all other states sboxw SHALL be 32'h0.
REQ-016 At the edge that leaves SERVE_x, the block SHALL load new_sboxw into x_result, set x_ack for exactly one cycle and return to IDLE.
REQ-017 Latency SHALL be fixed: a request sampled in IDLE at edge E0 gives x_ack high in the cycle after edge E0+1.
REQ-018 A requester is ineligible in any cycle where its own ack is high; the requester SHALL drop req in that cycle.
REQ-019 A request arriving while busy SHALL wait, with no loss, and SHALL be arbitrated at the next IDLE.
REQ-020 Priority without the macro: key beats enc when both are eligible in the same IDLE cycle.
REQ-021 Word changes after the latch in IDLE SHALL have no effect on the result being served.
REQ-022 Ack pulses SHALL never overlap; at most one service is in flight.

Reset
REQ-023 When reset is asserted, the block SHALL force IDLE, key_ack=0, enc_ack=0, key_result=0, enc_result=0, word_reg=0, sboxw=0, busy=0 and last_grant=ENC, all asynchronously.
REQ-024 Reset during SERVE_x SHALL abort the service with no ack; the requester SHALL re-request after reset.

Configuration
REQ-025 With macro AES_SBOX_ARB_RR_EN defined, the block SHALL use round-robin on ties: the requester not in last_grant wins, and last_grant updates on each grant.
REQ-026 Without AES_SBOX_ARB_RR_EN, REQ-020 fixed priority applies and last_grant is not implemented.

Verification
REQ-027 Key only: key_word=32'h00000000 -> sboxw=32'h00000000 in SERVE_KEY; key_ack two edges after the request, with key_result=32'h63636363.
REQ-028 Enc only: enc_word=32'h09cf4f3c -> enc_ack two edges later, with enc_result=32'h018a84eb; key_ack stays 0.
REQ-029 Both raised together, repeated 3 times, without the macro: order K,K,K while key_req stays up; enc is served only after key_req drops.
REQ-030 Both held continuously with AES_SBOX_ARB_RR_EN defined: grant order SHALL be K,E,K,E, and each ack SHALL be 3 cycles apart.
REQ-031 Reset asserted in SERVE_ENC -> no enc_ack, enc_result=0, busy=0 and sboxw=0 immediately; after release, the re-request completes normally.
REQ-032 enc_word changed the cycle after the latch -> enc_result SHALL reflect the original word.

Source files
------------

// File: rtl/aes_sbox_arbiter_if.sv
// Bus between the two SubWord requesters, the shared 4-byte S-box and aes_sbox_arbiter.
// Handshake: x_req is held high with x_word stable until a one-cycle x_ack; x_result is valid
// in the ack cycle and holds until the next x service; the requester drops x_req in the ack cycle.
interface aes_sbox_arbiter_if;
  logic        key_req;
  logic [31:0] key_word;
  logic        key_ack;
  logic [31:0] key_result;
  logic        enc_req;
  logic [31:0] enc_word;
  logic        enc_ack;
  logic [31:0] enc_result;
  logic [31:0] sboxw;
  logic [31:0] new_sboxw;
  logic        busy;
  logic [1:0]  fsm_state;

  modport slave (
    input  key_req, key_word, enc_req, enc_word, new_sboxw,
    output key_ack, key_result, enc_ack, enc_result, sboxw, busy, fsm_state
  );

  modport master (
    output key_req, key_word, enc_req, enc_word, new_sboxw,
    input  key_ack, key_result, enc_ack, enc_result, sboxw, busy, fsm_state
  );
endinterface

// File: rtl/aes_sbox_arbiter.sv
// Shares one combinational 4-byte AES S-box between key expansion and the cipher datapath.
// Define AES_SBOX_ARB_RR_EN for round-robin tie breaking; otherwise key has fixed priority.
module aes_sbox_arbiter (
  input logic               clk,
  input logic               reset,
  aes_sbox_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SERVE_KEY = 2'd1,
    SERVE_ENC = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] word_reg;
  logic [31:0] word_next;
  logic        key_ack;
  logic        enc_ack;
  logic [31:0] key_result;
  logic [31:0] enc_result;
  logic        elig_key;
  logic        elig_enc;
  logic        grant_key;
  logic        grant_enc;

  // No grant while any ack is high: the finishing requester is dropping its req, and the
  // turnaround cycle keeps back-to-back services exactly three cycles apart.
  assign elig_key = bus.key_req & ~key_ack & ~enc_ack;
  assign elig_enc = bus.enc_req & ~enc_ack & ~key_ack;

`ifdef AES_SBOX_ARB_RR_EN
  localparam logic LAST_KEY = 1'b0;
  localparam logic LAST_ENC = 1'b1;

  logic last_grant;

  assign grant_key = elig_key & (~elig_enc | (last_grant == LAST_ENC));
  assign grant_enc = elig_enc & ~grant_key;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant <= LAST_ENC;
    end else if (state == IDLE) begin
      if (grant_key) begin
        last_grant <= LAST_KEY;
      end else if (grant_enc) begin
        last_grant <= LAST_ENC;
      end
    end
  end
`else
  assign grant_key = elig_key;
  assign grant_enc = elig_enc & ~elig_key;
`endif

  always_comb begin
    state_next = state;
    word_next  = word_reg;
    case (state)
      IDLE: begin
        if (grant_key) begin
          word_next  = bus.key_word;
          state_next = SERVE_KEY;
        end else if (grant_enc) begin
          word_next  = bus.enc_word;
          state_next = SERVE_ENC;
        end
      end
      SERVE_KEY: state_next = IDLE;
      SERVE_ENC: state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Leaving a SERVE state captures the S-box output; a reset mid-service drops it unacked.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      word_reg   <= 32'h0;
      key_ack    <= 1'b0;
      enc_ack    <= 1'b0;
      key_result <= 32'h0;
      enc_result <= 32'h0;
    end else begin
      state    <= state_next;
      word_reg <= word_next;
      key_ack  <= (state == SERVE_KEY);
      enc_ack  <= (state == SERVE_ENC);
      if (state == SERVE_KEY) begin
        key_result <= bus.new_sboxw;
      end
      if (state == SERVE_ENC) begin
        enc_result <= bus.new_sboxw;
      end
    end
  end

  assign bus.sboxw      = ((state == SERVE_KEY) || (state == SERVE_ENC)) ? word_reg : 32'h0;
  assign bus.busy       = (state != IDLE);
  assign bus.key_ack    = key_ack;
  assign bus.enc_ack    = enc_ack;
  assign bus.key_result = key_result;
  assign bus.enc_result = enc_result;
  assign bus.fsm_state  = state;

endmodule

// File: tb/tb_aes_sbox_arbiter.sv
// Directed bench for aes_sbox_arbiter: vector table plus sequences for contention, reset
// abort and word change after latch. A behavioural S-box stands in for the shared S-box.
module tb_aes_sbox_arbiter;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  typedef struct {
    logic        key_req;
    logic [31:0] key_word;
    logic        enc_req;
    logic [31:0] enc_word;
    logic        key_first;
    logic [31:0] exp_key;
    logic [31:0] exp_enc;
  } vec_t;

  logic clk;
  logic reset;
  aes_sbox_arbiter_if bus();

  aes_sbox_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  assign bus.new_sboxw = sub_word(bus.sboxw);

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard: {is_enc, result} in expected ack order, plus the word each service drives
  logic [32:0] exp_q[$];
  logic [31:0] word_q[$];
  int n_vec = 0;
  int n_bad = 0;
  int key_more = 0;
  int enc_more = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic is_enc, input logic [31:0] word, input logic [31:0] res);
    exp_q.push_back({is_enc, res});
    word_q.push_back(word);
  endtask

  task automatic collect(input int first_lat, input int gap, input int budget);
    int cyc;
    int last;
    int n;
    bit raise_k;
    bit raise_e;
    logic [32:0] e;
    cyc = 0; last = 0; n = 0; raise_k = 0; raise_e = 0;
    while (exp_q.size() != 0 && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (bus.busy && word_q.size() != 0) check("sboxw_serve", bus.sboxw, word_q[0]);
      else if (!bus.busy) check("sboxw_idle", bus.sboxw, 32'h0);
      check("ack_overlap", 32'(bus.key_ack & bus.enc_ack), 32'h0);
      if (raise_k) bus.key_req = 1'b1;
      if (raise_e) bus.enc_req = 1'b1;
      raise_k = 0;
      raise_e = 0;
      if (bus.key_ack || bus.enc_ack) begin
        if (n == 0) check("first_latency", 32'(cyc), 32'(first_lat));
        else if (gap > 0) check("ack_gap", 32'(cyc - last), 32'(gap));
        last = cyc;
        n++;
      end
      if (bus.key_ack) begin
        if (exp_q.size() == 0) begin
          check("unexpected_key_ack", 32'h1, 32'h0);
        end else begin
          e = exp_q.pop_front();
          void'(word_q.pop_front());
          check("key_ack_owner", 32'(e[32]), 32'h0);
          check("key_result", bus.key_result, e[31:0]);
        end
        bus.key_req = 1'b0;
        if (key_more > 0) begin
          key_more--;
          raise_k = 1;
        end
      end
      if (bus.enc_ack) begin
        if (exp_q.size() == 0) begin
          check("unexpected_enc_ack", 32'h1, 32'h0);
        end else begin
          e = exp_q.pop_front();
          void'(word_q.pop_front());
          check("enc_ack_owner", 32'(e[32]), 32'h1);
          check("enc_result", bus.enc_result, e[31:0]);
        end
        bus.enc_req = 1'b0;
        if (enc_more > 0) begin
          enc_more--;
          raise_e = 1;
        end
      end
    end
    if (exp_q.size() != 0) begin
      check("ack_timeout_pending", 32'(exp_q.size()), 32'h0);
      exp_q.delete();
      word_q.delete();
    end
    bus.key_req = 1'b0;
    bus.enc_req = 1'b0;
  endtask

  task automatic check_quiet(input string name);
    @(negedge clk);
    check(name, {30'h0, bus.key_ack, bus.enc_ack}, 32'h0);
  endtask

  vec_t vecs[5];

  initial begin
    bus.key_req  = 1'b0;
    bus.key_word = 32'h0;
    bus.enc_req  = 1'b0;
    bus.enc_word = 32'h0;
    reset        = 1'b1;

    vecs[0] = '{1'b1, 32'h00000000, 1'b0, 32'h0,        1'b1, 32'h63636363, 32'h0};
    vecs[1] = '{1'b0, 32'h0,        1'b1, 32'h09cf4f3c, 1'b0, 32'h0,        32'h018a84eb};
    vecs[2] = '{1'b1, 32'h01020304, 1'b1, 32'h0a0b0c0d, 1'b1, 32'h7c777bf2, 32'h672bfed7};
    vecs[3] = '{1'b1, 32'hff000000, 1'b0, 32'h0,        1'b1, 32'h16636363, 32'h0};
    vecs[4] = '{1'b0, 32'h0,        1'b1, 32'h53535353, 1'b0, 32'h0,        32'hedededed};

    // reset state
    repeat (2) @(negedge clk);
    check("rst_key_ack",    32'(bus.key_ack), 32'h0);
    check("rst_enc_ack",    32'(bus.enc_ack), 32'h0);
    check("rst_key_result", bus.key_result, 32'h0);
    check("rst_enc_result", bus.enc_result, 32'h0);
    check("rst_sboxw",      bus.sboxw, 32'h0);
    check("rst_busy",       32'(bus.busy), 32'h0);
    check("rst_state",      32'(bus.fsm_state), 32'h0);
    reset = 1'b0;

    // table vectors
    for (int i = 0; i < 5; i++) begin
      repeat ($urandom_range(1, 3)) @(negedge clk);
      bus.key_req  = vecs[i].key_req;
      bus.key_word = vecs[i].key_word;
      bus.enc_req  = vecs[i].enc_req;
      bus.enc_word = vecs[i].enc_word;
      if (vecs[i].key_first) begin
        if (vecs[i].key_req) push_exp(1'b0, vecs[i].key_word, vecs[i].exp_key);
        if (vecs[i].enc_req) push_exp(1'b1, vecs[i].enc_word, vecs[i].exp_enc);
      end else begin
        if (vecs[i].enc_req) push_exp(1'b1, vecs[i].enc_word, vecs[i].exp_enc);
        if (vecs[i].key_req) push_exp(1'b0, vecs[i].key_word, vecs[i].exp_key);
      end
      collect(2, 3, 30);
      check_quiet("ack_one_cycle");
    end

    // contention: both requesters keep coming back
    repeat (2) @(negedge clk);
    bus.key_req  = 1'b1;
    bus.key_word = 32'h00112233;
    bus.enc_req  = 1'b1;
    bus.enc_word = 32'h3c4fcf09;
`ifdef AES_SBOX_ARB_RR_EN
    key_more = 1;
    enc_more = 1;
    push_exp(1'b0, 32'h00112233, 32'h638293c3);
    push_exp(1'b1, 32'h3c4fcf09, 32'heb848a01);
    push_exp(1'b0, 32'h00112233, 32'h638293c3);
    push_exp(1'b1, 32'h3c4fcf09, 32'heb848a01);
`else
    key_more = 2;
    enc_more = 0;
    push_exp(1'b0, 32'h00112233, 32'h638293c3);
    push_exp(1'b0, 32'h00112233, 32'h638293c3);
    push_exp(1'b0, 32'h00112233, 32'h638293c3);
    push_exp(1'b1, 32'h3c4fcf09, 32'heb848a01);
`endif
    collect(2, 3, 40);
    key_more = 0;
    enc_more = 0;
    check_quiet("contention_quiet");

    // reset in the middle of an enc service
    @(negedge clk);
    bus.enc_req  = 1'b1;
    bus.enc_word = 32'h3243f6a8;
    @(negedge clk);
    check("abort_serving_state", 32'(bus.fsm_state), 32'h2);
    check("abort_serving_sboxw", bus.sboxw, 32'h3243f6a8);
    reset = 1'b1;
    #1;
    check("abort_enc_ack",    32'(bus.enc_ack), 32'h0);
    check("abort_enc_result", bus.enc_result, 32'h0);
    check("abort_key_result", bus.key_result, 32'h0);
    check("abort_busy",       32'(bus.busy), 32'h0);
    check("abort_sboxw",      bus.sboxw, 32'h0);
    @(negedge clk);
    check("abort_no_ack", {30'h0, bus.key_ack, bus.enc_ack}, 32'h0);
    reset = 1'b0;
    push_exp(1'b1, 32'h3243f6a8, 32'h231a42c2);
    collect(2, 0, 20);
    check_quiet("rereq_quiet");

    // word changes after latch; key arrives while busy and waits
    @(negedge clk);
    bus.enc_req  = 1'b1;
    bus.enc_word = 32'h00112233;
    @(negedge clk);
    check("latched_sboxw", bus.sboxw, 32'h00112233);
    bus.enc_word = 32'hdeadbeef;
    bus.key_req  = 1'b1;
    bus.key_word = 32'h01020304;
    push_exp(1'b1, 32'h00112233, 32'h638293c3);
    push_exp(1'b0, 32'h01020304, 32'h7c777bf2);
    collect(1, 3, 20);
    check_quiet("late_word_quiet");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
